store_buffer: RTL and testbench
===============================

# store_buffer

Word-granular store buffer between the pipeline memory stage and the data memory port. It captures every store the core issues (MemWrite, DataAdr, WriteData) into an in-order FIFO and drains entries to data memory through a valid/ready handshake. This lets the core retire stores without waiting on a slow memory. It sits directly downstream of the core's memory-stage write outputs and upstream of dmem.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- AW, 32, address width
- DW, 32, data width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- MemWrite  in  1  store request from memory stage
- DataAdr  in  AW  store address (word-aligned; bits [1:0] ignored)
- WriteData  in  DW  store data
- StoreStall  out  1  MemWrite & full; core must hold the store
- LdAdr  in  AW  load address for forwarding lookup
- LdHit  out  1  a buffered store matches LdAdr
- LdData  out  DW  data of youngest matching entry
- MemValid  out  1  head entry presented to dmem
- MemAdr  out  AW  head address
- MemWData  out  DW  head data
- MemReady  in  1  dmem accepts head this cycle
- Empty  out  1  no entries held; used by core for fences

## Operation
- Circular FIFO: head pointer (wr_ptr), tail pointer (rd_ptr), each log2(DEPTH) bits, wrap modulo DEPTH.
- Occupancy count is log2(DEPTH)+1 bits; full = (count == DEPTH); Empty = (count == 0).
- Push: MemWrite & ~full. Entry written at wr_ptr; wr_ptr increments.
- Pop: MemValid & MemReady. rd_ptr increments.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Full blocks push even if a pop occurs that cycle. There is no ready-to-stall combinational path.
- MemValid = ~Empty. MemAdr and MemWData come from the entry at rd_ptr, read directly from storage.
- Order: entries drain strictly in issue order. Duplicate addresses are not merged.
- Forwarding compares LdAdr[AW-1:2] against all valid entries. The youngest match (closest to wr_ptr-1) wins.
- A store being pushed in the same cycle is not visible to the lookup until the next cycle.
- A head being popped in the same cycle is still visible to the lookup that cycle.

## Timing
- Reset values: count=0, wr_ptr=0, rd_ptr=0, MemValid=0, Empty=1, StoreStall=0, LdHit=0, LdData=0. MemAdr and MemWData are don't-care while MemValid=0.
- Push-to-MemValid latency: 1 cycle. A store accepted at edge N is presented to dmem from cycle N+1.
- MemValid stays high, with stable MemAdr and MemWData, until MemReady is sampled high.
- Minimum residency: 1 cycle. Throughput: 1 store per cycle when MemReady is held high.
- StoreStall, LdHit and LdData are combinational from the current state and inputs.
- Reset mid-operation: every buffered store is discarded at the next edge. The core is responsible for not resetting with stores pending.
- MemWrite asserted while reset is high: ignored.

## Configuration
- STORE_FWD_EN defined: forwarding comparators are built; LdHit and LdData behave as described in Operation.
- STORE_FWD_EN not defined: LdHit is tied to 0 and LdData to 0, and no comparators are built. The core must then stall loads until Empty=1.

## Structure
- The shared package sb_pkg holds:
  - the sb_entry_t struct (adr, data);
  - the default localparams SB_DEPTH=4 and SB_AW=SB_DW=32.
- One natural sub-module, sb_fwd_match: a combinational youngest-match priority selector over the entry array and a valid mask. It is instantiated only under STORE_FWD_EN.

## Test plan
- Reset, then a single store of DataAdr=132, WriteData=32'hABCDE02E with MemReady=1: MemValid rises the next cycle with MemAdr=132 and MemWData=ABCDE02E, pops in that cycle, and Empty=1 one cycle later.
- Fill with MemReady=0 using 4 stores to addresses 0x100..0x10C (data 1..4), then issue a 5th store to 0x110: StoreStall=1 and count stays 4. Raise MemReady: dmem sees 0x100..0x10C in order, and the 5th store is accepted once count drops to 3.
- Push and pop in the same cycle at count=2 for 10 cycles: count stays 2, pointers wrap past DEPTH, and drained data matches issue order.
- Forwarding (with STORE_FWD_EN): store 0x200=0xAAAA then 0x200=0xBBBB, then set LdAdr=0x200: LdHit=1 and LdData=0xBBBB. With LdAdr=0x204: LdHit=0. Without the macro: LdHit=0 in both cases.
- Reset asserted with 3 entries pending: after the next edge Empty=1 and MemValid=0, and none of the discarded stores appears on Mem* afterwards.

Source files
------------

// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared types and default sizing for the store buffer.
//   sb_entry_t : one buffered store (word address + data) at the default widths
//   SB_DEPTH   : default number of entries (power of two, >= 2)
//   SB_AW      : default address width
//   SB_DW      : default data width
// -----------------------------------------------------------------------------
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage : sb_pkg

// File: rtl/sb_fwd_match.sv
// -----------------------------------------------------------------------------
// sb_fwd_match
// Combinational youngest-match selector for store-to-load forwarding.
// Scans the entries from oldest to youngest relative to wr_ptr, so the entry
// nearest wr_ptr-1 that is valid and whose tag matches wins.
// Ports:
//   tag    in  TW          word address of the load
//   tags   in  DEPTH x TW  word address of every slot
//   datas  in  DEPTH x DW  data of every slot
//   valid  in  DEPTH       slot holds a live store
//   wr_ptr in  log2(DEPTH) next slot to be written
//   hit    out 1           some valid slot matches
//   data   out DW          data of the youngest match, 0 when no hit
// -----------------------------------------------------------------------------
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int TW    = 30,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [TW-1:0]             tag,
  input  logic [DEPTH-1:0][TW-1:0]  tags,
  input  logic [DEPTH-1:0][DW-1:0]  datas,
  input  logic [DEPTH-1:0]          valid,
  input  logic [PW-1:0]             wr_ptr,
  output logic                      hit,
  output logic [DW-1:0]             data
);

  logic [PW-1:0] idx;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    // k = DEPTH lands on wr_ptr itself (the oldest slot when full); k = 1 is
    // the youngest. Later matches overwrite earlier ones.
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (valid[idx] && (tags[idx] == tag)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule : sb_fwd_match

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// In-order word store buffer between the memory stage and data memory. Stores
// are queued in a circular FIFO and drained to dmem over a valid/ready
// handshake; optionally, loads can be forwarded from buffered stores.
// Build option: define STORE_FWD_EN to build the forwarding comparators;
// otherwise LdHit and LdData are tied to 0.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   MemWrite/DataAdr/WriteData  store request from the memory stage
//   StoreStall           store presented while full; core must hold it
//   LdAdr/LdHit/LdData   forwarding lookup for a load address
//   MemValid/MemAdr/MemWData/MemReady  head entry handshake to dmem
//   Empty                nothing buffered (used for fences)
// -----------------------------------------------------------------------------
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic          StoreStall,
  input  logic [AW-1:0] LdAdr,
  output logic          LdHit,
  output logic [DW-1:0] LdData,
  output logic          MemValid,
  output logic [AW-1:0] MemAdr,
  output logic [DW-1:0] MemWData,
  input  logic          MemReady,
  output logic          Empty
);

  localparam int           PW       = $clog2(DEPTH);
  localparam logic [PW:0]  FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  logic [AW-1:0] adr_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  assign full       = (count == FULL_CNT);
  assign Empty      = (count == '0);
  assign MemValid   = ~Empty;
  assign StoreStall = MemWrite & full;
  // Full blocks the push even when the head drains this cycle, so MemReady
  // never reaches StoreStall combinationally.
  assign push       = MemWrite & ~full;
  assign pop        = MemValid & MemReady;

  assign MemAdr     = adr_mem[rd_ptr];
  assign MemWData   = data_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage is deliberately not reset; the pointers and count
  // decide which slots are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      adr_mem[wr_ptr]  <= DataAdr;
      data_mem[wr_ptr] <= WriteData;
    end
  end

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0][AW-3:0] fwd_tags;
  logic [DEPTH-1:0][DW-1:0] fwd_datas;
  logic [DEPTH-1:0]         fwd_valid;
  logic                     unused_ld;

  // A slot is live when its distance from rd_ptr is below count. The head
  // being popped this cycle is still live here; a store being pushed is not.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign fwd_tags[i]  = adr_mem[i][AW-1:2];
    assign fwd_datas[i] = data_mem[i];
    assign fwd_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .TW    (AW-2),
    .DW    (DW)
  ) u_fwd_match (
    .tag    (LdAdr[AW-1:2]),
    .tags   (fwd_tags),
    .datas  (fwd_datas),
    .valid  (fwd_valid),
    .wr_ptr (wr_ptr),
    .hit    (LdHit),
    .data   (LdData)
  );

  // Byte offset of the load does not take part in the word match.
  assign unused_ld = ^LdAdr[1:0];
`else
  logic unused_ld;

  assign LdHit     = 1'b0;
  assign LdData    = '0;
  assign unused_ld = ^LdAdr;
`endif

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Self-checking bench for store_buffer at default sizing. A queue of stores
// serves as the reference: push appends, pop removes the front, reset empties
// it, and a load lookup searches the queue from the back.
// -----------------------------------------------------------------------------
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = SB_DEPTH;

  logic          clk;
  logic          reset;
  logic          MemWrite;
  logic [31:0]   DataAdr;
  logic [31:0]   WriteData;
  logic          StoreStall;
  logic [31:0]   LdAdr;
  logic          LdHit;
  logic [31:0]   LdData;
  logic          MemValid;
  logic [31:0]   MemAdr;
  logic [31:0]   MemWData;
  logic          MemReady;
  logic          Empty;

  store_buffer #(.DEPTH(DEPTH), .AW(SB_AW), .DW(SB_DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .StoreStall (StoreStall),
    .LdAdr      (LdAdr),
    .LdHit      (LdHit),
    .LdData     (LdData),
    .MemValid   (MemValid),
    .MemAdr     (MemAdr),
    .MemWData   (MemWData),
    .MemReady   (MemReady),
    .Empty      (Empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  sb_entry_t model_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle against the model,
  // then advance the model across the rising edge.
  task automatic cycle(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] ld, input logic rst);
    logic        exp_hit;
    logic [31:0] exp_ld;
    bit          was_full;
    bit          was_valid;
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = wd;
    MemReady  = rdy;
    LdAdr     = ld;
    reset     = rst;
    @(negedge clk);

    was_full  = (model_q.size() == DEPTH);
    was_valid = (model_q.size() != 0);

    exp_hit = 1'b0;
    exp_ld  = '0;
`ifdef STORE_FWD_EN
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].adr[31:2] == ld[31:2]) begin
        exp_hit = 1'b1;
        exp_ld  = model_q[i].data;
        break;
      end
    end
`endif

    check("empty",    Empty,      !was_valid);
    check("memvalid", MemValid,   was_valid);
    check("stall",    StoreStall, mw && was_full);
    check("ldhit",    LdHit,      exp_hit);
    check("lddata",   LdData,     exp_ld);
    if (was_valid) begin
      check("memadr",   MemAdr,   model_q[0].adr);
      check("memwdata", MemWData, model_q[0].data);
    end

    if (rst) begin
      model_q.delete();
    end else begin
      if (was_valid && rdy) void'(model_q.pop_front());
      if (mw && !was_full) model_q.push_back('{adr: adr, data: wd});
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, rdy, '0, 1'b0);
  endtask

  initial begin
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    MemReady  = 1'b0;
    LdAdr     = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then a single store with MemReady held high.
    idle(1'b0);
    cycle(1'b1, 32'd132, 32'hABCDE02E, 1'b1, '0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill with MemReady low, hold a 5th store, then drain.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h100 + 32'(4*i), 32'(i+1), 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h110, 32'd5, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h110, 32'd5, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h110, 32'd5, 1'b1, '0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Simultaneous push and pop at count 2; pointers wrap several times.
    cycle(1'b1, 32'h300, 32'h30, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h304, 32'h31, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h308 + 32'(4*i), 32'h32 + 32'(i), 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Forwarding: youngest duplicate wins; a neighbouring word misses.
    cycle(1'b1, 32'h200, 32'hAAAA, 1'b0, 32'h200, 1'b0);
    cycle(1'b1, 32'h200, 32'hBBBB, 1'b0, 32'h200, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 32'h200, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 32'h203, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 32'h204, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Reset with 3 entries pending; a store during reset is ignored.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h400 + 32'(4*i), 32'h40 + 32'(i), 1'b0, 32'h400, 1'b0);
    cycle(1'b1, 32'h500, 32'h50, 1'b1, 32'h400, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 32'h400, 1'b0);
    cycle(1'b1, 32'h600, 32'h60, 1'b1, 32'h400, 1'b0);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Randomized traffic over a small address window to provoke hits.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] l;
      a = 32'h700 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      l = 32'h700 + 32'($urandom_range(0, 8) * 4) + 32'($urandom_range(0, 3));
      cycle(($urandom_range(0, 3) != 0), a, $urandom(),
            ($urandom_range(0, 2) == 0), l, ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_store_buffer
